// File: rtl/clk_cal_display_pkg.sv
// rtl/clk_cal_display_pkg.sv - shared constants, page enum and digit decode for the clock/calendar display
package clk_cal_disp_pkg;

  localparam int DEF_REFRESH_DIV = 100000;
  localparam int DEF_BLANK_CYC   = 16;
  localparam int DEF_PAGE_HOLD   = 250;

  localparam int TIME_W = 24;
  localparam int DATE_W = 32;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    PAGE_TIME = 1'b0,
    PAGE_DATE = 1'b1
  } page_e;

  // mode[1] set selects auto-alternate regardless of mode[0]
  localparam logic [1:0] MODE_TIME = 2'b00;
  localparam logic [1:0] MODE_DATE = 2'b01;
  localparam int         MODE_AUTO_BIT = 1;

  // Non-BCD nibbles show 'E' so corrupt RTC data is visible rather than silent
  function automatic logic [6:0] digit_pattern(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_E;
    endcase
  endfunction

endpackage

// File: rtl/clk_cal_display_if.sv
// rtl/clk_cal_display_if.sv - BCD inputs, mode select and multiplexed display outputs
interface clk_cal_display_if;
  import clk_cal_disp_pkg::*;

  logic [TIME_W-1:0] time_bcd;
  logic [DATE_W-1:0] date_bcd;
  logic [1:0]        mode;
  logic [7:0]        an;
  logic [6:0]        seg;
  logic              dp;
  logic              page;

  modport master (
    output time_bcd, date_bcd, mode,
    input  an, seg, dp, page
  );

  modport slave (
    input  time_bcd, date_bcd, mode,
    output an, seg, dp, page
  );

endinterface

// File: rtl/clk_cal_display_bcd_to_seg.sv
// rtl/clk_cal_display_bcd_to_seg.sv - nibble plus dash/blank overrides to active-low segment pattern
module bcd_to_seg
  import clk_cal_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);

  // blank overrides dash, dash overrides the nibble value
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      seg = digit_pattern(nibble);
    end
  end

endmodule

// File: rtl/clk_cal_display.sv
// rtl/clk_cal_display.sv - 8-digit multiplexed time/date display with tear-free snapshot and page FSM
module clk_cal_display
  import clk_cal_disp_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLANK_CYC   = DEF_BLANK_CYC,
  parameter int PAGE_HOLD   = DEF_PAGE_HOLD
) (
  input  logic               clk_100MHz,
  input  logic               rst_n,
  clk_cal_display_if.slave   bus
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FCNT_W = (PAGE_HOLD > 0) ? $clog2(PAGE_HOLD + 1) : 1;
  localparam int SNAP_W = TIME_W + DATE_W;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYC);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(PAGE_HOLD - 1);

  logic [SLOT_W-1:0] slot_cnt;
  logic [2:0]        scan_idx;
  logic              frame_start;

  logic [SNAP_W-1:0] stage_a;
  logic [SNAP_W-1:0] stage_b;
  logic [SNAP_W-1:0] snap;
  logic [SNAP_W-1:0] snap_next;

  page_e             state;
  page_e             state_next;
  logic              auto_on;
  logic              auto_on_next;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] fcnt_next;

  logic [TIME_W-1:0] time_v;
  logic [DATE_W-1:0] date_v;
  logic [3:0]        nib;
  logic              dash;
  logic              blank;
  logic              dp_d;
  logic [6:0]        seg_d;
  logic [7:0]        an_d;

  // Frame starts on the first cycle of the leftmost digit slot
  assign frame_start = (slot_cnt == '0) && (scan_idx == 3'd7);

  // Slot timer and scan index; index walks 7 down to 0 then wraps to 7
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      scan_idx <= 3'd7;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      scan_idx <= scan_idx - 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // A snapshot is only taken when two consecutive samples agree, so a
  // mid-update RTC value never reaches the digits
  assign snap_next = (frame_start && (stage_a == stage_b)) ? stage_b : snap;

  // Two-stage input capture plus the per-frame snapshot
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      stage_a <= '0;
      stage_b <= '0;
      snap    <= '0;
    end else begin
      stage_a <= {bus.time_bcd, bus.date_bcd};
      stage_b <= stage_a;
      snap    <= snap_next;
    end
  end

  // Page FSM state, auto-mode flag and frame counter
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PAGE_TIME;
      auto_on <= 1'b0;
      fcnt    <= '0;
    end else begin
      state   <= state_next;
      auto_on <= auto_on_next;
      fcnt    <= fcnt_next;
    end
  end

  // Page transitions happen only on frame starts; the first auto frame
  // just clears the counter and keeps whatever page was showing
  always_comb begin
    state_next   = state;
    auto_on_next = auto_on;
    fcnt_next    = fcnt;
    if (frame_start) begin
      if (bus.mode[MODE_AUTO_BIT]) begin
        auto_on_next = 1'b1;
        if (!auto_on) begin
          fcnt_next = '0;
        end else if (fcnt == FCNT_LAST) begin
          fcnt_next  = '0;
          state_next = (state == PAGE_TIME) ? PAGE_DATE : PAGE_TIME;
        end else begin
          fcnt_next = fcnt + 1'b1;
        end
      end else begin
        auto_on_next = 1'b0;
        fcnt_next    = '0;
        state_next   = (bus.mode == MODE_DATE) ? PAGE_DATE : PAGE_TIME;
      end
    end
  end

  // Digits are chosen from the post-update snapshot and page so the new
  // page and new data appear together on the first digit of a frame
  assign time_v = snap_next[SNAP_W-1:DATE_W];
  assign date_v = snap_next[DATE_W-1:0];

  // Per-slot digit source, dash/blank control and decimal point
  always_comb begin
    nib   = 4'd0;
    dash  = 1'b0;
    blank = 1'b0;
    dp_d  = 1'b1;
    if (state_next == PAGE_DATE) begin
      nib  = date_v[{scan_idx, 2'b00} +: 4];
      dp_d = !((scan_idx == 3'd6) || (scan_idx == 3'd4));
    end else begin
      case (scan_idx)
        3'd7: begin
          nib   = time_v[23:20];
          blank = (time_v[23:20] == 4'd0);
        end
        3'd6:    nib  = time_v[19:16];
        3'd5:    dash = 1'b1;
        3'd4:    nib  = time_v[15:12];
        3'd3:    nib  = time_v[11:8];
        3'd2:    dash = 1'b1;
        3'd1:    nib  = time_v[7:4];
        default: nib  = time_v[3:0];
      endcase
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .nibble (nib),
    .dash   (dash),
    .blank  (blank),
    .seg    (seg_d)
  );

  // Anodes stay dark for the first BLANK_CYC cycles of each slot
  assign an_d = (slot_cnt < BLANK_END) ? 8'hFF : ~(8'h01 << scan_idx);

  // Registered display outputs
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      bus.an  <= 8'hFF;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= an_d;
      bus.seg <= seg_d;
      bus.dp  <= dp_d;
    end
  end

  assign bus.page = state;

endmodule

// File: tb/tb_clk_cal_display.sv
// tb/tb_clk_cal_display.sv - self-checking bench for clk_cal_display
module tb_clk_cal_display;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int PH    = 3;
  localparam int FRAME = 8 * RD;

  logic clk_100MHz = 1'b0;
  logic rst_n      = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  clk_cal_display_if bus ();

  logic [23:0] t_in;
  logic [31:0] d_in;
  logic [1:0]  m_in;

  assign bus.time_bcd = t_in;
  assign bus.date_bcd = d_in;
  assign bus.mode     = m_in;

  clk_cal_display #(
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC),
    .PAGE_HOLD   (PH)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .bus        (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int          ne;
  logic [55:0] p1, p2, snap_m;
  logic        page_m, auto_m;
  int          fcnt_m;
  logic [6:0]  cap_seg [8];
  logic        cap_dp  [8];

  function automatic logic [6:0] seg_from(input string on);
    logic [6:0] lit = 7'h00;
    for (int i = 0; i < on.len(); i++) lit[int'(on[i]) - 97] = 1'b1;
    return ~lit;
  endfunction

  function automatic logic [6:0] pat_of(input byte ch);
    case (ch)
      "0": return seg_from("abcdef");
      "1": return seg_from("bc");
      "2": return seg_from("abdeg");
      "3": return seg_from("abcdg");
      "4": return seg_from("bcfg");
      "5": return seg_from("acdfg");
      "6": return seg_from("acdefg");
      "7": return seg_from("abc");
      "8": return seg_from("abcdefg");
      "9": return seg_from("abcdfg");
      "-": return seg_from("g");
      "E": return seg_from("adefg");
      default: return 7'h7F;
    endcase
  endfunction

  function automatic byte ch_of(input logic [3:0] n);
    return (n > 4'd9) ? "E" : byte'(8'h30 + 8'(n));
  endfunction

  function automatic byte frame_char(input logic pg, input int k, input logic [55:0] s);
    logic [23:0] tm;
    logic [31:0] dt;
    tm = s[55:32];
    dt = s[31:0];
    if (pg) return ch_of(dt[4*k +: 4]);
    case (k)
      7: return (tm[23:20] == 4'd0) ? " " : ch_of(tm[23:20]);
      6: return ch_of(tm[19:16]);
      4: return ch_of(tm[15:12]);
      3: return ch_of(tm[11:8]);
      1: return ch_of(tm[7:4]);
      0: return ch_of(tm[3:0]);
      default: return "-";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      if (n_err <= 25) $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ne = 0; p1 = '0; p2 = '0; snap_m = '0;
    page_m = 1'b0; auto_m = 1'b0; fcnt_m = 0;
  endtask

  task automatic tick();
    int c, k;
    logic [7:0]  an_e;
    logic [55:0] cur;
    cur = {t_in, d_in};
    @(posedge clk_100MHz);
    c = ne % RD;
    k = 7 - ((ne / RD) % 8);
    if (c == 0 && k == 7) begin
      if (p1 == p2) snap_m = p2;
      if (m_in[1]) begin
        if (!auto_m) begin
          auto_m = 1'b1;
          fcnt_m = 0;
        end else begin
          fcnt_m++;
          if (fcnt_m == PH) begin
            page_m = ~page_m;
            fcnt_m = 0;
          end
        end
      end else begin
        auto_m = 1'b0;
        fcnt_m = 0;
        page_m = m_in[0];
      end
    end
    p2 = p1;
    p1 = cur;
    an_e = (c < BC) ? 8'hFF : ~(8'h01 << k);
    @(negedge clk_100MHz);
    check("an", bus.an, an_e);
    check("page", bus.page, page_m);
    if (an_e != 8'hFF) begin
      check("seg", bus.seg, pat_of(frame_char(page_m, k, snap_m)));
      check("dp", bus.dp, (page_m && (k == 6 || k == 4)) ? 1'b0 : 1'b1);
    end
    if (c == BC) begin
      cap_seg[k] = bus.seg;
      cap_dp[k]  = bus.dp;
    end
    ne++;
  endtask

  task automatic finish_frame();
    while (ne % FRAME != 0) tick();
  endtask

  task automatic full_frame();
    tick();
    finish_frame();
  endtask

  task automatic run_until(input int phase);
    do tick(); while (ne % FRAME != phase);
  endtask

  task automatic check_frame(input string tag, input string txt, input logic [7:0] dpm);
    for (int k = 7; k >= 0; k--) begin
      check(tag, cap_seg[k], pat_of(txt[7-k]));
      check(tag, cap_dp[k], dpm[k]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, bus.an, 8'hFF);
    check({tag, "_seg"}, bus.seg, 7'h7F);
    check({tag, "_dp"}, bus.dp, 1'b1);
    check({tag, "_page"}, bus.page, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int enter, togg, e, hold;
    logic last_pg;

    t_in = 24'h090537;
    d_in = 32'h31122025;
    m_in = 2'b00;
    model_reset();

    repeat (3) @(posedge clk_100MHz);
    #2;
    check_reset_outputs("reset");

    @(negedge clk_100MHz);
    rst_n = 1'b1;
    model_reset();

    full_frame();
    check_frame("reset_frame", " 0-00-00", 8'hFF);
    full_frame();
    check_frame("time_page", " 9-05-37", 8'hFF);

    run_until(20);
    m_in = 2'b01;
    finish_frame();
    check_frame("mode_mid_frame", " 9-05-37", 8'hFF);
    full_frame();
    check_frame("date_page", "31122025", 8'hAF);

    m_in = 2'b00;
    t_in = 24'h123B45;
    full_frame();
    full_frame();
    check_frame("bad_nibble", "12-3E-45", 8'hFF);

    t_in = 24'h090537;
    full_frame();
    run_until(30);
    t_in = 24'h090538;
    finish_frame();
    check_frame("sec_hold", " 9-05-37", 8'hFF);
    full_frame();
    check_frame("sec_next", " 9-05-38", 8'hFF);

    run_until(60);
    repeat (10) begin
      t_in = (t_in == 24'h090538) ? 24'h090539 : 24'h090538;
      tick();
    end
    t_in = 24'h090539;
    finish_frame();
    check_frame("tear_guard", " 9-05-38", 8'hFF);
    full_frame();
    check_frame("after_tear", " 9-05-39", 8'hFF);

    run_until(10);
    m_in    = 2'b10;
    enter   = ne - (ne % FRAME) + FRAME;
    togg    = 0;
    last_pg = bus.page;
    repeat (640) begin
      tick();
      e = ne - 1;
      if (bus.page !== last_pg) begin
        togg++;
        check("auto_toggle_edge", e, enter + 3 * FRAME * togg);
        last_pg = bus.page;
      end
    end
    check("auto_toggle_count", togg, 3);

    for (int i = 0; i < 16; i++) begin
      m_in = 2'($urandom_range(0, 3));
      t_in = 24'($urandom);
      d_in = $urandom;
      if ($urandom_range(0, 3) == 0) t_in[23:20] = 4'd0;
      hold = $urandom_range(1, 150);
      repeat (hold) tick();
    end

    run_until(37);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_in = 2'b00;
    repeat (2) @(posedge clk_100MHz);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    model_reset();
    tick();
    tick();
    check("an7_blank", bus.an[7], 1'b1);
    tick();
    check("an7_on", bus.an[7], 1'b0);
    finish_frame();
    check_frame("post_reset", " 0-00-00", 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/clk_cal_display.md
CLK_CAL_DISPLAY -- requirements
Module: clk_cal_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk_100MHz cycles per digit slot (8 slots = 125 Hz frame); SHALL be >= BLANK_CYC+2.
REQ-002 Parameter BLANK_CYC, default 16, all-anodes-off cycles at start of each slot (anti-ghosting).
REQ-003 Parameter PAGE_HOLD, default 250, frames per page in auto mode.
REQ-004 clk_100MHz  in  1  sole clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 time_bcd  in  24  {hr_10s,hr_1s,min_10s,min_1s,sec_10s,sec_1s}, 4-bit BCD each.
REQ-007 date_bcd  in  32  {d_10s,d_1s,m_10s,m_1s,c_10s,c_1s,y_10s,y_1s}, 4-bit BCD each.
REQ-008 mode  in  2  00 time page, 01 date page, 1x auto-alternate.
REQ-009 an  out  8  digit anodes, active-low, bit 7 leftmost.
REQ-010 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  out  1  decimal point, active-low.
REQ-012 page  out  1  displayed page: 0 time, 1 date.

Function
REQ-013 Slot counter counts 0..REFRESH_DIV-1; scan index steps 7,6,...,0,7 at each slot wrap; frame boundary = first cycle of slot 7.
REQ-014 In slot k, an SHALL be all ones for slot cycles 0..BLANK_CYC-1, then an[k]=0 only, through cycle REFRESH_DIV-1.
REQ-015 All outputs registered; seg/dp/an change exactly one cycle after the slot-counter value that selects them.
REQ-016 Input capture: time_bcd/date_bcd registered every cycle into stage A, A copied into stage B.
REQ-017 At each frame boundary, snapshot SHALL load from B only if A==B; otherwise snapshot retained for that frame (no tearing within a frame).
REQ-018 Time page, digits 7..0: hr_10s, hr_1s, dash, min_10s, min_1s, dash, sec_10s, sec_1s.
REQ-019 Time page: hr_10s==0 SHALL be blanked (seg all ones).
REQ-020 Date page, digits 7..0: d_10s, d_1s, m_10s, m_1s, c_10s, c_1s, y_10s, y_1s; dp=0 on digits 6 and 4, else dp=1.
REQ-021 Time page: dp=1 on all digits.
REQ-022 Decode: 0-9 standard seven-segment; dash = g only; nibble >9 SHALL display 'E' (a,d,e,f,g on).
REQ-023 Page FSM states TIME, DATE; transitions evaluated only at frame boundaries.
REQ-024 mode 00 -> TIME, mode 01 -> DATE at next frame boundary.
REQ-025 mode 1x: frame counter increments each frame boundary; on reaching PAGE_HOLD, page toggles and counter clears.
REQ-026 Entering auto mode from fixed mode: counter clears, current page retained; mode change mid-frame takes effect at next boundary only.
REQ-027 page output equals FSM state, updated at the frame boundary with the first digit of the new page.

Reset
REQ-028 rst_n=0 asynchronously forces an=8'hFF, seg=7'h7F, dp=1, page=0, FSM=TIME, slot counter 0, scan index 7, frame counter 0, stages A/B and snapshot all zero.
REQ-029 After rst_n release, first frame boundary SHALL occur at the first active cycle; mid-frame reset restarts scanning at slot 7 cycle 0.

Structure
REQ-030 Package clk_cal_disp_pkg: segment pattern constants (0-9, dash, E, blank), page enum, mode encodings, parameter defaults.
REQ-031 One sub-module bcd_to_seg: combinational nibble + dash/blank controls -> 7-bit active-low pattern.

Verification (REFRESH_DIV=8, BLANK_CYC=2, PAGE_HOLD=3)
REQ-032 Reset mid-scan -> an=FF, seg=7F, dp=1, page=0 immediately; after release an[7]=0 from cycle 3 of slot 7.
REQ-033 mode=00, time 09:05:37 -> digits 7..0: blank,9,dash,0,5,dash,3,7; dp=1 throughout.
REQ-034 mode=01, date 31-12-2025 -> 3,1,1,2,2,0,2,5; dp=0 on digits 6 and 4 only.
REQ-035 mode=10 -> page toggles every 3 frames (every 192 cycles), exactly at slot-7 start.
REQ-036 sec_1s changed 7->8 mid-frame -> current frame shows 7, next shows 8; input toggled each cycle across boundary -> snapshot unchanged.
REQ-037 min_1s=4'hB -> digit 3 shows 'E' pattern.
